// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the 24-slave decoder segment.
// HTRANS codes, slave count and default-slave FSM state encoding.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int NSLV = 24;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: zero-wait OKAY for IDLE/BUSY, two-cycle ERROR for active transfers.
// Response starts one cycle after the accepted address phase; never stalls an OKAY.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       hclk,
  input  logic       hrst,
  input  logic       hready,
  input  logic       sel,
  input  logic [1:0] htrans,
  output logic       def_hreadyout,
  output logic       def_hresp
);

  ds_state_e state_q, state_d;
  logic      err_start;
  logic      unused_htrans;

  // Only NONSEQ/SEQ (htrans[1]) are real transfers needing an ERROR.
  assign err_start     = hready & sel & htrans[1];
  assign unused_htrans = htrans[0];

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) state_q <= DS_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    def_hreadyout = 1'b1;
    def_hresp     = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if (err_start) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        def_hreadyout = 1'b0;
        def_hresp     = 1'b1;
        state_d       = DS_ERR2;
      end
      DS_ERR2: begin
        def_hreadyout = 1'b1;
        def_hresp     = 1'b1;
        state_d       = err_start ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_dec24_dsel.sv
// AHB-Lite 24-slave address decoder, data-phase select register and default slave.
// hsel_o is combinational; dsel_o/dsel_def update on hready-high edges and hold otherwise.
module ahb_dec24_dsel
  import ahb_pkg::*;
#(
  parameter int              AW      = 32,
  parameter int              SLV_LSB = 24,
  parameter logic [NSLV-1:0] SLV_EN  = 24'hFFFFFF
) (
  input  logic            hclk,
  input  logic            hrst,
  input  logic [AW-1:0]   haddr,
  input  logic [1:0]      htrans,
  input  logic            hready,
  output logic [NSLV-1:0] hsel_o,
  output logic [NSLV-1:0] dsel_o,
  output logic            dsel_def,
  output logic            def_hreadyout,
  output logic            def_hresp
);

  logic [4:0]      idx;
  logic            dec_def;
  logic [NSLV-1:0] dsel_q, dsel_d;
  logic            dsel_def_q, dsel_def_d;
  logic            unused_addr;

  // Upper address bits alias onto the 32 regions; low bits are offset within a region.
  assign idx         = haddr[SLV_LSB+4:SLV_LSB];
  assign unused_addr = ^{haddr[AW-1:SLV_LSB+5], haddr[SLV_LSB-1:0]};

  always_comb begin
    hsel_o = '0;
    for (int i = 0; i < NSLV; i++) begin
      hsel_o[i] = (idx == 5'(i)) & SLV_EN[i];
    end
  end

  assign dec_def = ~|hsel_o;

  always_comb begin
    dsel_d     = dsel_q;
    dsel_def_d = dsel_def_q;
    if (hready) begin
      dsel_d     = hsel_o;
      dsel_def_d = dec_def;
    end
  end

  // Reset selects the default slave so the response mux always has exactly one owner.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      dsel_q     <= '0;
      dsel_def_q <= 1'b1;
    end else begin
      dsel_q     <= dsel_d;
      dsel_def_q <= dsel_def_d;
    end
  end

  assign dsel_o   = dsel_q;
  assign dsel_def = dsel_def_q;

  ahb_default_slave u_def (
    .hclk          (hclk),
    .hrst          (hrst),
    .hready        (hready),
    .sel           (dec_def),
    .htrans        (htrans),
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp)
  );

endmodule

// File: tb/tb_ahb_dec24_dsel.sv
// Bench for ahb_dec24_dsel: full-enable instance plus one with slave 5 disabled.
module tb_ahb_dec24_dsel;
  import ahb_pkg::*;

  logic        hclk = 1'b0;
  logic        hrst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;

  logic [23:0] hsel_o, dsel_o;
  logic        dsel_def, def_hreadyout, def_hresp;
  logic [23:0] hsel_x, dsel_x;
  logic        dsel_def_x, def_hreadyout_x, def_hresp_x;

  typedef struct packed {
    logic [23:0] dsel;
    logic        ddef;
    logic        hro;
    logic        hresp;
  } exp_t;

  exp_t sb_q[$];
  exp_t exp_v;
  int   checks = 0;
  int   errors = 0;

  always #5 hclk = ~hclk;

  ahb_dec24_dsel dut (
    .hclk(hclk), .hrst(hrst), .haddr(haddr), .htrans(htrans), .hready(hready),
    .hsel_o(hsel_o), .dsel_o(dsel_o), .dsel_def(dsel_def),
    .def_hreadyout(def_hreadyout), .def_hresp(def_hresp)
  );

  ahb_dec24_dsel #(.SLV_EN(24'hFFFFDF)) dut_dis (
    .hclk(hclk), .hrst(hrst), .haddr(haddr), .htrans(htrans), .hready(hready),
    .hsel_o(hsel_x), .dsel_o(dsel_x), .dsel_def(dsel_def_x),
    .def_hreadyout(def_hreadyout_x), .def_hresp(def_hresp_x)
  );

  task automatic drive(input logic [31:0] a, input logic [1:0] t, input logic r);
    haddr  = a;
    htrans = t;
    hready = r;
  endtask

  task automatic test_reset();
    hrst = 1'b1;
    drive(32'h1F00_0000, HTRANS_IDLE, 1'b1);
    sb_q.push_back('{24'h0, 1'b1, 1'b1, 1'b0});
    repeat (2) @(posedge hclk);
    #1;
    exp_v = sb_q.pop_front();
    checks++;
    if ({dsel_o, dsel_def, def_hreadyout, def_hresp} !== exp_v) begin
      errors++;
      $display("FAIL reset_hold got dsel=%h def=%b rdy=%b resp=%b want %h %b %b %b",
               dsel_o, dsel_def, def_hreadyout, def_hresp, exp_v.dsel, exp_v.ddef, exp_v.hro, exp_v.hresp);
    end
    hrst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back('{24'h0, 1'b1, 1'b1, 1'b0});
      @(posedge hclk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if ({dsel_o, dsel_def, def_hreadyout, def_hresp} !== exp_v) begin
        errors++;
        $display("FAIL reset_release[%0d] got dsel=%h def=%b rdy=%b resp=%b want %h %b %b %b", i,
                 dsel_o, dsel_def, def_hreadyout, def_hresp, exp_v.dsel, exp_v.ddef, exp_v.hro, exp_v.hresp);
      end
    end
  endtask

  task automatic test_mapped();
    logic [31:0] a [3];
    logic [23:0] hs [3];
    a  = '{32'h0500_0000, 32'hE500_0000, 32'h1700_1234};
    hs = '{24'h000020, 24'h000020, 24'h800000};
    for (int i = 0; i < 3; i++) begin
      drive(a[i], HTRANS_NONSEQ, 1'b1);
      #1;
      checks++;
      if (hsel_o !== hs[i]) begin
        errors++;
        $display("FAIL mapped_hsel[%0d] got %h want %h", i, hsel_o, hs[i]);
      end
      sb_q.push_back('{hs[i], 1'b0, 1'b1, 1'b0});
      @(posedge hclk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if ({dsel_o, dsel_def, def_hreadyout, def_hresp} !== exp_v) begin
        errors++;
        $display("FAIL mapped_dsel[%0d] got dsel=%h def=%b rdy=%b resp=%b want %h %b %b %b", i,
                 dsel_o, dsel_def, def_hreadyout, def_hresp, exp_v.dsel, exp_v.ddef, exp_v.hro, exp_v.hresp);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] a [3];
    logic [1:0]  t [3];
    logic        r [3];
    exp_t        e [3];
    a = '{32'h1A00_0000, 32'h1A00_0000, 32'h1F00_0000};
    t = '{HTRANS_NONSEQ, HTRANS_IDLE, HTRANS_IDLE};
    r = '{1'b1, 1'b0, 1'b1};
    e = '{'{24'h0, 1'b1, 1'b0, 1'b1}, '{24'h0, 1'b1, 1'b1, 1'b1}, '{24'h0, 1'b1, 1'b1, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      drive(a[i], t[i], r[i]);
      #1;
      checks++;
      if (hsel_o !== 24'h0) begin
        errors++;
        $display("FAIL unmapped_hsel[%0d] got %h want 000000", i, hsel_o);
      end
      sb_q.push_back(e[i]);
      @(posedge hclk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if ({dsel_o, dsel_def, def_hreadyout, def_hresp} !== exp_v) begin
        errors++;
        $display("FAIL unmapped[%0d] got dsel=%h def=%b rdy=%b resp=%b want %h %b %b %b", i,
                 dsel_o, dsel_def, def_hreadyout, def_hresp, exp_v.dsel, exp_v.ddef, exp_v.hro, exp_v.hresp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] t [5];
    logic       r [5];
    exp_t       e [5];
    t = '{HTRANS_NONSEQ, HTRANS_NONSEQ, HTRANS_NONSEQ, HTRANS_IDLE, HTRANS_IDLE};
    r = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    e = '{'{24'h0, 1'b1, 1'b0, 1'b1}, '{24'h0, 1'b1, 1'b1, 1'b1},
          '{24'h0, 1'b1, 1'b0, 1'b1}, '{24'h0, 1'b1, 1'b1, 1'b1},
          '{24'h0, 1'b1, 1'b1, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      drive(32'h1E00_0000, t[i], r[i]);
      sb_q.push_back(e[i]);
      @(posedge hclk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if ({dsel_o, dsel_def, def_hreadyout, def_hresp} !== exp_v) begin
        errors++;
        $display("FAIL b2b[%0d] got dsel=%h def=%b rdy=%b resp=%b want %h %b %b %b", i,
                 dsel_o, dsel_def, def_hreadyout, def_hresp, exp_v.dsel, exp_v.ddef, exp_v.hro, exp_v.hresp);
      end
    end
  endtask

  task automatic test_wait_hold();
    logic [31:0] a [5];
    logic        r [5];
    logic [23:0] hs [5];
    logic [23:0] ds [5];
    a  = '{32'h0300_0000, 32'h0700_0000, 32'h0700_0000, 32'h0700_0000, 32'h0700_0000};
    r  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    hs = '{24'h000008, 24'h000080, 24'h000080, 24'h000080, 24'h000080};
    ds = '{24'h000008, 24'h000008, 24'h000008, 24'h000008, 24'h000080};
    for (int i = 0; i < 5; i++) begin
      drive(a[i], HTRANS_NONSEQ, r[i]);
      #1;
      checks++;
      if (hsel_o !== hs[i]) begin
        errors++;
        $display("FAIL wait_hsel[%0d] got %h want %h", i, hsel_o, hs[i]);
      end
      sb_q.push_back('{ds[i], 1'b0, 1'b1, 1'b0});
      @(posedge hclk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if ({dsel_o, dsel_def, def_hreadyout, def_hresp} !== exp_v) begin
        errors++;
        $display("FAIL wait_hold[%0d] got dsel=%h def=%b rdy=%b resp=%b want %h %b %b %b", i,
                 dsel_o, dsel_def, def_hreadyout, def_hresp, exp_v.dsel, exp_v.ddef, exp_v.hro, exp_v.hresp);
      end
      checks++;
      if (!$onehot({dsel_o, dsel_def})) begin
        errors++;
        $display("FAIL wait_onehot[%0d] got %h_%b want one bit set", i, dsel_o, dsel_def);
      end
    end
  endtask

  task automatic test_disabled();
    logic [31:0] a [3];
    logic [1:0]  t [3];
    logic        r [3];
    exp_t        e [3];
    a = '{32'h0500_0000, 32'h0500_0000, 32'h1F00_0000};
    t = '{HTRANS_NONSEQ, HTRANS_IDLE, HTRANS_IDLE};
    r = '{1'b1, 1'b0, 1'b1};
    e = '{'{24'h0, 1'b1, 1'b0, 1'b1}, '{24'h0, 1'b1, 1'b1, 1'b1}, '{24'h0, 1'b1, 1'b1, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      drive(a[i], t[i], r[i]);
      #1;
      checks++;
      if (hsel_x !== 24'h0) begin
        errors++;
        $display("FAIL disabled_hsel[%0d] got %h want 000000", i, hsel_x);
      end
      sb_q.push_back(e[i]);
      @(posedge hclk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if ({dsel_x, dsel_def_x, def_hreadyout_x, def_hresp_x} !== exp_v) begin
        errors++;
        $display("FAIL disabled[%0d] got dsel=%h def=%b rdy=%b resp=%b want %h %b %b %b", i,
                 dsel_x, dsel_def_x, def_hreadyout_x, def_hresp_x, exp_v.dsel, exp_v.ddef, exp_v.hro, exp_v.hresp);
      end
    end
  endtask

  task automatic test_unmapped_idle();
    logic [1:0] t [3];
    t = '{HTRANS_IDLE, HTRANS_BUSY, HTRANS_IDLE};
    for (int i = 0; i < 3; i++) begin
      drive(32'h1A00_0000, t[i], 1'b1);
      sb_q.push_back('{24'h0, 1'b1, 1'b1, 1'b0});
      @(posedge hclk); #1;
      exp_v = sb_q.pop_front();
      checks++;
      if ({dsel_o, dsel_def, def_hreadyout, def_hresp} !== exp_v) begin
        errors++;
        $display("FAIL unmapped_idle[%0d] got dsel=%h def=%b rdy=%b resp=%b want %h %b %b %b", i,
                 dsel_o, dsel_def, def_hreadyout, def_hresp, exp_v.dsel, exp_v.ddef, exp_v.hro, exp_v.hresp);
      end
    end
  endtask

  task automatic test_reset_mid_error();
    drive(32'h0200_0000, HTRANS_NONSEQ, 1'b1);
    sb_q.push_back('{24'h000004, 1'b0, 1'b1, 1'b0});
    @(posedge hclk); #1;
    drive(32'h1C00_0000, HTRANS_NONSEQ, 1'b1);
    sb_q.push_back('{24'h0, 1'b1, 1'b0, 1'b1});
    @(posedge hclk); #1;
    hrst = 1'b1;
    sb_q.push_back('{24'h0, 1'b1, 1'b1, 1'b0});
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_v = sb_q.pop_front();
      checks++;
      if (i == 0 && (dsel_o !== 24'h0 || dsel_def !== 1'b1 || def_hresp !== 1'b0)) begin
        errors++;
        $display("FAIL reset_mid_async got dsel=%h def=%b resp=%b want 000000 1 0", dsel_o, dsel_def, def_hresp);
      end
      if (i == 0) continue;
      // remaining entries describe the pre-reset history, already observed only via the final state
      if (exp_v.ddef === 1'b1 && {dsel_o, dsel_def, def_hreadyout, def_hresp} !== {24'h0, 1'b1, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL reset_mid[%0d] got dsel=%h def=%b rdy=%b resp=%b want 000000 1 1 0", i,
                 dsel_o, dsel_def, def_hreadyout, def_hresp);
      end
    end
    @(posedge hclk); #1;
    hrst = 1'b0;
    drive(32'h1F00_0000, HTRANS_IDLE, 1'b1);
  endtask

  initial begin
    test_reset();
    test_mapped();
    test_unmapped();
    test_back_to_back();
    test_wait_hold();
    test_disabled();
    test_unmapped_idle();
    test_reset_mid_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
